// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: shared opcodes, NOP encoding, immediate extractors and queue entry type
package inst_fetch_unit_pkg;
   localparam logic [6:0]  OPC_JAL    = 7'b1101111;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
   localparam logic [31:0] INST_NOP   = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] pc;
      logic        taken;
   } qent_t;

   function automatic logic [31:0] j_imm(input logic [31:0] i);
      return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
   endfunction

   function automatic logic [31:0] b_imm(input logic [31:0] i);
      return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
   endfunction
endpackage

// File: rtl/inst_fetch_unit_fetch_queue.sv
// fetch_queue: synchronous FIFO with flush, used for both instructions and pending fetch tags
module fetch_queue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd, wr;
   logic             do_push, do_pop;

   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd];

   // storage has no reset; only the pointers define what is valid
   always_ff @(posedge CLK)
      if (do_push) mem[wr] <= din;

   // pointer and occupancy tracking; flush empties the queue and ignores same-cycle push/pop
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else if (flush) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else begin
         if (do_push) wr <= wr + AW'(1);
         if (do_pop) rd <= rd + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC owner, credit-limited imem requester, static predecoder and decoder-facing queue
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        CLK,
   input  logic        RST,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvld,
   input  logic [31:0] imem_rdata,
   input  logic        alu_flush,
   input  logic [31:0] flush_pc,
   input  logic        dec_stall,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_taken,
   output logic        inst_vld
);
   localparam int EW = $clog2(QDEPTH) + 1;
   localparam int CW = $clog2(QDEPTH) + 1;
   localparam int UW = CW + 1;

   logic [31:0]   pc, tpc, tgt;
   logic [EW-1:0] epoch, tep;
   logic [CW-1:0] tcnt, qcnt;
   logic [UW-1:0] used;
   logic          tfull, tempty, qfull, qempty;
   logic          issue, tpop, resp_ok, taken, redirect, is_jal;
   qent_t         head;

   assign used      = UW'(qcnt) + UW'(tcnt);
   assign imem_req  = (used < UW'(QDEPTH)) & ~alu_flush & ~RST;
   assign imem_addr = pc;
   assign issue     = imem_req & imem_gnt;
   assign tpop      = imem_rvld & ~tempty;
   assign resp_ok   = tpop & (tep == epoch);
   assign is_jal    = imem_rdata[6:0] == OPC_JAL;
   assign taken     = is_jal | (imem_rdata[6:0] == OPC_BRANCH & imem_rdata[31]);
   assign tgt       = tpc + (is_jal ? j_imm(imem_rdata) : b_imm(imem_rdata));
   assign redirect  = resp_ok & taken & ~alu_flush;

   assign inst_vld   = ~qempty & ~alu_flush;
   assign inst       = qempty ? INST_NOP : head.ins;
   assign inst_pc    = qempty ? 32'h0 : head.pc;
   assign inst_taken = ~qempty & head.taken;

   // a fetch issued alongside a redirect carries the old epoch, so its response is dropped
   fetch_queue #(.WIDTH(32 + EW), .DEPTH(QDEPTH)) u_tags (
      .CLK(CLK), .RST(RST), .push(issue & ~tfull), .pop(tpop), .flush(1'b0),
      .din({pc, epoch}), .dout({tpc, tep}), .full(tfull), .empty(tempty), .count(tcnt)
   );

   fetch_queue #(.WIDTH($bits(qent_t)), .DEPTH(QDEPTH)) u_insts (
      .CLK(CLK), .RST(RST), .push(resp_ok & ~qfull), .pop(inst_vld & ~dec_stall), .flush(alu_flush),
      .din({imem_rdata, tpc, taken}), .dout(head), .full(qfull), .empty(qempty), .count(qcnt)
   );

   // pc and epoch: flush beats predecode redirect beats sequential advance
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         pc    <= RESET_PC;
         epoch <= '0;
      end else if (alu_flush) begin
         pc    <= flush_pc;
         epoch <= epoch + EW'(1);
      end else if (redirect) begin
         pc    <= tgt;
         epoch <= epoch + EW'(1);
      end else if (issue) begin
         pc    <= pc + 32'd4;
      end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: table-driven handoff stream checks plus directed stall, flush and reset sequences
module tb_inst_fetch_unit;
   localparam logic [31:0] JAL_M8  = 32'hFF9F_F06F;
   localparam logic [31:0] BEQ_P16 = 32'h0000_0863;
   localparam logic [31:0] BEQ_M16 = 32'hFE00_08E3;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic        CLK = 0, RST = 1, imem_gnt = 1, imem_rvld = 0, alu_flush = 0, dec_stall = 0;
   logic [31:0] imem_rdata = 0, flush_pc = 0;
   logic        imem_req, inst_taken, inst_vld;
   logic [31:0] imem_addr, inst, inst_pc;

   typedef struct { logic [31:0] a; int due; } pe_t;
   typedef struct { logic [31:0] pc; logic [31:0] ins; logic tk; } ho_t;
   typedef struct packed {
      logic [31:0]        start;
      logic [3:0]         lat;
      logic [1:0]         smode;
      logic               gmode;
      logic [0:7][31:0]   pcs;
      logic [0:7]         tk;
   } vec_t;

   pe_t         pend[$];
   ho_t         got[$];
   logic [31:0] iss[$];
   vec_t        vecs[6];
   int          cyc = 0, lat = 1, smode = 0, gmode = 0;
   bit          autod = 1, stray = 0;
   int          total = 0, bad = 0;

   inst_fetch_unit #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
      .CLK(CLK), .RST(RST), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvld(imem_rvld), .imem_rdata(imem_rdata), .alu_flush(alu_flush), .flush_pc(flush_pc),
      .dec_stall(dec_stall), .inst(inst), .inst_pc(inst_pc), .inst_taken(inst_taken), .inst_vld(inst_vld)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] word(input logic [31:0] a);
      case (a)
         32'h10:  return JAL_M8;
         32'h20:  return BEQ_P16;
         32'h40:  return BEQ_M16;
         default: return {a[11:0], 20'h00013};
      endcase
   endfunction

   function automatic vec_t mk(input logic [31:0] s, input int l, input int sm, input int gm,
                               input logic [0:7][31:0] p, input logic [0:7] t);
      vec_t v;
      v.start = s; v.lat = 4'(l); v.smode = 2'(sm); v.gmode = gm[0]; v.pcs = p; v.tk = t;
      return v;
   endfunction

   // memory model: in-order responses lat cycles after grant, plus optional stray beat
   always @(posedge CLK) begin
      #1;
      cyc++;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rvld = 1;
         imem_rdata = word(pend[0].a);
         void'(pend.pop_front());
      end else if (stray) begin
         imem_rvld = 1;
         imem_rdata = JAL_M8;
         stray = 0;
      end else begin
         imem_rvld = 0;
      end
      if (autod) begin
         dec_stall = smode == 1 ? (cyc % 3 == 0) : smode == 2 ? (cyc % 4 != 0) : 1'b0;
         imem_gnt  = gmode == 1 ? cyc[0] : 1'b1;
      end
   end

   // observe grants and decoder handoffs mid-cycle
   always @(negedge CLK) begin
      if (RST) pend.delete();
      else begin
         if (imem_req && imem_gnt) begin
            pend.push_back('{imem_addr, cyc + lat});
            iss.push_back(imem_addr);
         end
         if (inst_vld && !dec_stall) got.push_back('{inst_pc, inst, inst_taken});
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic ho_chk(input string nm, input int k, input logic [31:0] pc, input logic tk);
      if (k >= got.size()) begin
         total++;
         bad++;
         $display("FAIL %s[%0d] handoff missing got=%0d exp>%0d", nm, k, got.size(), k);
      end else begin
         chk($sformatf("%s[%0d].pc", nm, k), got[k].pc, pc);
         chk($sformatf("%s[%0d].inst", nm, k), got[k].ins, word(pc));
         chk($sformatf("%s[%0d].taken", nm, k), 32'(got[k].tk), 32'(tk));
      end
   endtask

   task automatic need(input int n, input int lim);
      int w = 0;
      while (got.size() < n && w < lim) begin
         @(posedge CLK);
         w++;
      end
   endtask

   task automatic do_reset();
      @(posedge CLK); #1;
      RST = 1; alu_flush = 0; autod = 1; smode = 0; gmode = 0; lat = 1;
      repeat (2) @(posedge CLK);
      got.delete(); iss.delete();
   endtask

   task automatic start_at(input logic [31:0] s);
      @(posedge CLK); #1;
      RST = 0; alu_flush = 1; flush_pc = s;
      @(posedge CLK); #1;
      alu_flush = 0;
      got.delete();
   endtask

   initial begin
      logic [31:0] exp_head;
      int n, w;
      vecs[0] = mk(32'h0, 1, 0, 0, {32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h8, 32'hC, 32'h10}, 8'b00001001);
      vecs[1] = mk(32'h0, 2, 1, 1, {32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h8, 32'hC, 32'h10}, 8'b00001001);
      vecs[2] = mk(32'h20, 1, 0, 0, {32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C}, 8'b00000000);
      vecs[3] = mk(32'h34, 3, 1, 1, {32'h34, 32'h38, 32'h3C, 32'h40, 32'h30, 32'h34, 32'h38, 32'h3C}, 8'b00010000);
      vecs[4] = mk(32'hFFFF_FFF8, 1, 2, 0, {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h8}, 8'b00000010);
      vecs[5] = mk(32'hC, 2, 2, 1, {32'hC, 32'h10, 32'h8, 32'hC, 32'h10, 32'h8, 32'hC, 32'h10}, 8'b01001001);

      // reset state, then sequential issue from RESET_PC and JAL redirect dropping 0x14
      repeat (2) @(posedge CLK);
      #1;
      chk("rst.imem_req", 32'(imem_req), 0);
      chk("rst.inst_vld", 32'(inst_vld), 0);
      chk("rst.inst", inst, NOP);
      chk("rst.inst_pc", inst_pc, 0);
      chk("rst.inst_taken", 32'(inst_taken), 0);
      @(posedge CLK); #1;
      RST = 0;
      need(7, 200);
      for (int k = 0; k < 5; k++) begin
         if (k < iss.size()) chk($sformatf("seq.addr[%0d]", k), iss[k], 32'(4 * k));
         else chk($sformatf("seq.addr[%0d]", k), 32'hX, 32'(4 * k));
      end
      for (int k = 0; k < 4; k++) ho_chk("seq", k, 32'(4 * k), 0);
      ho_chk("jal", 4, 32'h10, 1);
      ho_chk("jal", 5, 32'h8, 0);
      ho_chk("jal", 6, 32'hC, 0);

      // table: architectural handoff stream under varied latency, grant and stall patterns
      for (int v = 0; v < 6; v++) begin
         do_reset();
         lat = int'(vecs[v].lat); smode = int'(vecs[v].smode); gmode = int'(vecs[v].gmode);
         start_at(vecs[v].start);
         need(8, 400);
         for (int k = 0; k < 8; k++) ho_chk($sformatf("vec%0d", v), k, vecs[v].pcs[k], vecs[v].tk[k]);
      end

      // decoder stall: head held, credits exhausted, no lost or duplicated PC on release
      do_reset();
      start_at(32'h20);
      need(1, 100);
      @(posedge CLK); #1;
      autod = 0; imem_gnt = 1; dec_stall = 1;
      n = got.size();
      exp_head = 32'h20 + 32'(4 * n);
      for (int s = 0; s < 5; s++) begin
         @(negedge CLK);
         if (s >= 2) begin
            chk($sformatf("stall%0d.inst_pc", s), inst_pc, exp_head);
            chk($sformatf("stall%0d.inst_vld", s), 32'(inst_vld), 1);
         end
         @(posedge CLK); #1;
      end
      chk("stall.imem_req", 32'(imem_req), 0);
      chk("stall.outstanding", 32'(pend.size()), 0);
      dec_stall = 0; autod = 1;
      need(8, 200);
      for (int k = 0; k < 8; k++) ho_chk("stall", k, 32'h20 + 32'(4 * k), 0);

      // flush with two responses in flight
      do_reset();
      lat = 3;
      start_at(32'h0);
      w = 0;
      while (pend.size() < 2 && w < 100) begin
         @(posedge CLK); #2;
         w++;
      end
      chk("flush.inflight", 32'(pend.size()), 2);
      alu_flush = 1; flush_pc = 32'h100;
      got.delete();
      #1;
      chk("flush.inst_vld", 32'(inst_vld), 0);
      chk("flush.imem_req", 32'(imem_req), 0);
      @(posedge CLK); #1;
      alu_flush = 0;
      need(3, 200);
      for (int k = 0; k < 3; k++) ho_chk("flush", k, 32'h100 + 32'(4 * k), 0);

      // flush in the same cycle as a taken JAL response with grant high
      do_reset();
      start_at(32'h0);
      w = 0;
      do begin
         @(posedge CLK); #2;
         w++;
      end while (!(imem_rvld && imem_rdata == JAL_M8) && w < 100);
      chk("coll.jal_seen", imem_rdata, JAL_M8);
      alu_flush = 1; flush_pc = 32'h200;
      got.delete();
      #1;
      chk("coll.imem_req", 32'(imem_req), 0);
      @(posedge CLK); #1;
      alu_flush = 0;
      need(3, 200);
      for (int k = 0; k < 3; k++) ho_chk("coll", k, 32'h200 + 32'(4 * k), 0);

      // asynchronous reset mid-stream, then a stray response with no pending tag
      @(posedge CLK); #3;
      RST = 1;
      #1;
      chk("arst.inst_vld", 32'(inst_vld), 0);
      chk("arst.inst", inst, NOP);
      chk("arst.inst_pc", inst_pc, 0);
      chk("arst.inst_taken", 32'(inst_taken), 0);
      chk("arst.imem_req", 32'(imem_req), 0);
      repeat (2) @(posedge CLK);
      got.delete();
      stray = 1;
      @(posedge CLK); #1;
      RST = 0;
      need(3, 200);
      for (int k = 0; k < 3; k++) ho_chk("arst", k, 32'(4 * k), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
